// File: rtl/alu_pkg.sv
// Shared ALU function codes, FSM state type and default datapath width.
// The ALU control decoder imports these same codes, so producer and consumer stay in sync.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SLL  = 3'b001;
  localparam logic [2:0] ALU_XOR  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_MUL  = 3'b100;
  localparam logic [2:0] ALU_SUB  = 3'b101;
  localparam logic [2:0] ALU_ADDI = 3'b110;
  localparam logic [2:0] ALU_SRAI = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_shift_add_mul.sv
// Iterative shift-add multiplier that retires one multiplier bit per cycle.
// done_o flags the final step; product_o carries that step's sum so the caller can capture it on the same edge.
module alu_shift_add_mul #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             abort_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] multiplicand_i,
  input  logic [WIDTH-1:0] multiplier_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o
);

  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0] mplier_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             busy_reg;
  logic [WIDTH-1:0] step_sum;

  assign step_sum  = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
  assign busy_o    = busy_reg;
  assign done_o    = busy_reg && (cnt_reg == '0);
  assign product_o = step_sum;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b0;
    end else if (abort_i) begin
      acc_reg    <= '0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b0;
    end else if (start_i) begin
      acc_reg    <= '0;
      mcand_reg  <= multiplicand_i;
      mplier_reg <= multiplier_i;
      cnt_reg    <= CNT_W'(WIDTH - 1);
      busy_reg   <= 1'b1;
    end else if (busy_reg) begin
      acc_reg    <= step_sum;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      if (cnt_reg == '0) begin
        busy_reg <= 1'b0;
      end else begin
        cnt_reg <= cnt_reg - 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready on both sides: single-cycle ops plus an iterative MUL.
// The result register holds data_o/zero_o stable until the downstream stage takes it.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH   = ALU_WIDTH,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [2:0]       ALUfunc_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             zero_o
);

  alu_state_e       state_reg;
  logic [WIDTH-1:0] data_reg;
  logic             valid_reg;
  logic             zero_reg;
  logic [WIDTH-1:0] alu_res;
  logic [SHAMT_W-1:0] shamt;
  logic             accept;
  logic             mul_start;
  logic             mul_busy;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  // DONE passes ready_i straight through so 1-cycle ops stream at full rate.
  assign ready_o   = !flush_i && ((state_reg == IDLE) || ((state_reg == DONE) && ready_i));
  assign accept    = valid_i && ready_o;
  assign mul_start = accept && (ALUfunc_i == ALU_MUL);

  assign valid_o = valid_reg;
  assign data_o  = data_reg;
  assign zero_o  = valid_reg && zero_reg;

  assign shamt = data2_i[SHAMT_W-1:0];

  always_comb begin
    alu_res = '0;
    case (ALUfunc_i)
      ALU_ADD, ALU_ADDI: alu_res = data1_i + data2_i;
      ALU_SUB:           alu_res = data1_i - data2_i;
      ALU_SLL:           alu_res = data1_i << shamt;
      ALU_XOR:           alu_res = data1_i ^ data2_i;
      ALU_AND:           alu_res = data1_i & data2_i;
      ALU_SRAI:          alu_res = $signed(data1_i) >>> shamt;
      default:           alu_res = '0;
    endcase
  end

  alu_shift_add_mul #(
    .WIDTH (WIDTH),
    .CNT_W (SHAMT_W)
  ) u_mul (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .abort_i        (flush_i),
    .start_i        (mul_start),
    .multiplicand_i (data1_i),
    .multiplier_i   (data2_i),
    .busy_o         (mul_busy),
    .done_o         (mul_done),
    .product_o      (mul_product)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg <= IDLE;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      zero_reg  <= 1'b0;
    end else if (flush_i) begin
      state_reg <= IDLE;
      valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (accept) begin
            if (ALUfunc_i == ALU_MUL) begin
              valid_reg <= 1'b0;
              state_reg <= MUL;
            end else begin
              data_reg  <= alu_res;
              zero_reg  <= (alu_res == '0);
              valid_reg <= 1'b1;
              state_reg <= DONE;
            end
          end else if ((state_reg == DONE) && ready_i) begin
            valid_reg <= 1'b0;
            state_reg <= IDLE;
          end
        end
        MUL: begin
          if (mul_done) begin
            data_reg  <= mul_product;
            zero_reg  <= (mul_product == '0);
            valid_reg <= 1'b1;
            state_reg <= DONE;
          end else if (!mul_busy) begin
            // Multiplier lost its job without finishing; recover rather than hang.
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
          valid_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed vector table, hand-written handshake/abort
// sequences and randomized ops compared against an arithmetic reference model.
module tb_alu_exec_unit;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [2:0]  ALUfunc_i = 3'd0;
  logic [31:0] data1_i = 32'd0;
  logic [31:0] data2_i = 32'd0;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic [31:0] data_o;
  logic        zero_o;

  int tests = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  alu_exec_unit dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .flush_i   (flush_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .ALUfunc_i (ALUfunc_i),
    .data1_i   (data1_i),
    .data2_i   (data2_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .data_o    (data_o),
    .zero_o    (zero_o)
  );

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end else begin
      $display("[TB] ok %s = %h", nm, got);
    end
  endtask

  // Reference: plain wide arithmetic, low 32 bits kept.
  function automatic logic [31:0] ref_alu(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] wide;
    int sh;
    sh = int'(b[4:0]);
    wide = 64'd0;
    case (f)
      3'd0, 3'd6: wide = {32'd0, a} + {32'd0, b};
      3'd5:       wide = {32'd0, a} - {32'd0, b};
      3'd1:       wide = {32'd0, a} << sh;
      3'd2:       wide = {32'd0, a ^ b};
      3'd3:       wide = {32'd0, a & b};
      3'd4:       wide = {32'd0, a} * {32'd0, b};
      default:    wide = {{32{a[31]}}, a} >> sh;
    endcase
    return wide[31:0];
  endfunction

  // Starts and ends at posedge+1; ready_i assumed 1 so the result retires right after it is seen.
  task automatic run_op(input string nm, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    int busy_ready;
    ALUfunc_i = f; data1_i = a; data2_i = b; valid_i = 1'b1;
    @(negedge clk_i);
    check({nm, " ready_o before accept"}, 32'(ready_o), 32'd1);
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    data1_i = $urandom; data2_i = $urandom; ALUfunc_i = 3'($urandom_range(0, 7));
    lat = 0;
    busy_ready = 0;
    do begin
      @(negedge clk_i);
      lat++;
      if (!valid_o && ready_o) busy_ready++;
    end while (!valid_o && lat < 100);
    check({nm, " latency"}, 32'(lat), 32'(exp_lat));
    if (exp_lat > 1) check({nm, " ready_o high while busy (cycles)"}, 32'(busy_ready), 32'd0);
    check({nm, " data_o"}, data_o, exp);
    check({nm, " zero_o"}, 32'(zero_o), 32'(exp == 32'd0));
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_no_valid(input string nm, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk_i);
      if (valid_o) seen++;
    end
    check({nm, " stray valid_o cycles"}, 32'(seen), 32'd0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{3'd0, 32'd7,          32'd5,          32'd12,         1};
    vecs[1] = '{3'd5, 32'd5,          32'd7,          32'hFFFF_FFFE,  1};
    vecs[2] = '{3'd2, 32'h0000_F0F0,  32'h0000_0FF0,  32'h0000_FF00,  1};
    vecs[3] = '{3'd3, 32'h0000_F0F0,  32'h0000_0FF0,  32'h0000_00F0,  1};
    vecs[4] = '{3'd1, 32'd1,          32'd31,         32'h8000_0000,  1};
    vecs[5] = '{3'd7, 32'h8000_0000,  32'd4,          32'hF800_0000,  1};
    vecs[6] = '{3'd5, 32'd9,          32'd9,          32'd0,          1};
    vecs[7] = '{3'd2, 32'd1,          32'd0,          32'd1,          1};
    vecs[8] = '{3'd4, 32'h0001_0001,  32'h0001_0001,  32'h0002_0001,  33};
    vecs[9] = '{3'd4, 32'hFFFF_FFFF,  32'd3,          32'hFFFF_FFFD,  33};

    // Reset state while held.
    #2;
    check("reset valid_o", 32'(valid_o), 32'd0);
    check("reset data_o", data_o, 32'd0);
    check("reset ready_o", 32'(ready_o), 32'd1);
    check("reset zero_o", 32'(zero_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;

    foreach (vecs[i]) begin
      run_op($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
    end

    // Backpressure: result held, ready_o follows ready_i, then a no-bubble handoff.
    begin
      logic [31:0] held;
      int unstable;
      int rdy_hi;
      ready_i = 1'b0;
      ALUfunc_i = 3'd0; data1_i = 32'd7; data2_i = 32'd5; valid_i = 1'b1;
      @(posedge clk_i);
      #1;
      valid_i = 1'b0;
      @(negedge clk_i);
      check("bp first result", data_o, 32'd12);
      held = data_o;
      unstable = 0;
      rdy_hi = 0;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk_i);
        if (data_o !== held || !valid_o) unstable++;
        if (ready_o) rdy_hi++;
      end
      check("bp data_o unstable cycles", 32'(unstable), 32'd0);
      check("bp ready_o high cycles", 32'(rdy_hi), 32'd0);
      @(posedge clk_i);
      #1;
      ready_i = 1'b1;
      ALUfunc_i = 3'd6; data1_i = 32'd0; data2_i = 32'hFFFF_FFFF; valid_i = 1'b1;
      @(negedge clk_i);
      check("bp ready_o passthrough", 32'(ready_o), 32'd1);
      @(posedge clk_i);
      #1;
      valid_i = 1'b0;
      @(negedge clk_i);
      check("bp next valid_o", 32'(valid_o), 32'd1);
      check("bp next data_o", data_o, 32'hFFFF_FFFF);
      @(posedge clk_i);
      #1;
    end

    // Flush in the middle of a MUL; an op offered during flush must not be taken.
    ALUfunc_i = 3'd4; data1_i = 32'd3; data2_i = 32'd4; valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    repeat (9) @(posedge clk_i);
    #1;
    flush_i = 1'b1;
    ALUfunc_i = 3'd0; data1_i = 32'd1; data2_i = 32'd1; valid_i = 1'b1;
    @(negedge clk_i);
    check("flush ready_o", 32'(ready_o), 32'd0);
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    valid_i = 1'b0;
    @(negedge clk_i);
    check("flush valid_o after", 32'(valid_o), 32'd0);
    check("flush ready_o after", 32'(ready_o), 32'd1);
    wait_no_valid("flush", 40);
    @(posedge clk_i);
    #1;
    run_op("post-flush add", 3'd0, 32'd100, 32'd23, 32'd123, 1);

    // Async reset in the middle of a MUL.
    ALUfunc_i = 3'd4; data1_i = 32'd6; data2_i = 32'd7; valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    repeat (9) @(posedge clk_i);
    #3;
    rst_i = 1'b0;
    #1;
    check("midmul reset valid_o", 32'(valid_o), 32'd0);
    check("midmul reset ready_o", 32'(ready_o), 32'd1);
    check("midmul reset data_o", data_o, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    wait_no_valid("midmul reset", 40);
    @(posedge clk_i);
    #1;

    // Async reset while a result is parked in DONE.
    ready_i = 1'b0;
    ALUfunc_i = 3'd2; data1_i = 32'h1234_5678; data2_i = 32'd0; valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    @(posedge clk_i);
    #3;
    rst_i = 1'b0;
    #1;
    check("done reset valid_o", 32'(valid_o), 32'd0);
    check("done reset data_o", data_o, 32'd0);
    check("done reset ready_o", 32'(ready_o), 32'd1);
    @(negedge clk_i);
    rst_i = 1'b1;
    ready_i = 1'b1;
    @(posedge clk_i);
    #1;

    // Random ops against the reference model.
    for (int i = 0; i < 150; i++) begin
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? a : $urandom;
      run_op($sformatf("rnd%0d f%0d", i, f), f, a, b, ref_alu(f, a, b), (f == 3'd4) ? 33 : 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
